// File: rtl/lab4_pkg.sv
// lab4_pkg: shared constants and state encoding for the lab4 sequencing blocks.
package lab4_pkg;
   localparam int WIDTH_DEF = 5;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [WIDTH_DEF-1:0] DZ_QUOTIENT = 5'b11111;
   typedef enum logic [1:0] {IDLE = ST_IDLE, CALC = ST_CALC, DONE = ST_DONE} state_t;
endpackage

// File: rtl/lab4_3.sv
// lab4_3: 5-bit ripple subtractor, out_d = in_a - in_b - in_c; out_c=1 means no borrow.
module lab4_3 (
   input  logic [4:0] in_a,
   input  logic [4:0] in_b,
   input  logic       in_c,
   output logic [4:0] out_d,
   output logic       out_c
);
   logic [4:0] nb;
   logic [5:0] c;
   assign nb   = ~in_b;
   assign c[0] = ~in_c;
   for (genvar i = 0; i < 5; i++) begin : g_fa
      assign out_d[i]  = in_a[i] ^ nb[i] ^ c[i];
      assign c[i+1]    = (in_a[i] & nb[i]) | (c[i] & (in_a[i] ^ nb[i]));
   end
   assign out_c = c[5];
endmodule

// File: rtl/lab4_div5_ctrl.sv
// lab4_div5_ctrl: sequential 5-bit restoring divider, one iteration per cycle on a
// shared ripple subtractor, valid/ready handshake on both sides.
module lab4_div5_ctrl
   import lab4_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_q,
   output logic [WIDTH-1:0] out_r,
   output logic             out_dz
);
   state_t           state, state_n;
   logic [CNT_W-1:0] count, count_n;
   logic [WIDTH-1:0] q, q_n, r, r_n, d, d_n, q_out_n, r_out_n;
   logic             dz_n, cout, ok;
   logic [WIDTH:0]   s;
   logic [WIDTH-1:0] diff, r_step, q_step;

   assign s = {r, q[WIDTH-1]};

   lab4_3 u_sub (
      .in_a (s[WIDTH-1:0]),
      .in_b (d),
      .in_c (1'b0),
      .out_d(diff),
      .out_c(cout)
   );

   // a shifted-out top bit means S >= 32 > D, so the subtraction cannot borrow
   assign ok     = s[WIDTH] | cout;
   assign r_step = ok ? diff : s[WIDTH-1:0];
   assign q_step = {q[WIDTH-2:0], ok};

   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;

   always_comb begin
      state_n = state;
      count_n = count;
      q_n     = q;
      r_n     = r;
      d_n     = d;
      q_out_n = out_q;
      r_out_n = out_r;
      dz_n    = out_dz;
      case (state)
         IDLE: if (in_valid) begin
            q_n     = in_a;
            d_n     = in_b;
            r_n     = '0;
            count_n = '0;
            if (in_b == '0) begin
               state_n = DONE;
               q_out_n = DZ_QUOTIENT;
               r_out_n = in_a;
               dz_n    = 1'b1;
            end else begin
               state_n = CALC;
            end
         end
         CALC: begin
            q_n     = q_step;
            r_n     = r_step;
            count_n = count + 1'b1;
            if (count == CNT_W'(WIDTH - 1)) begin
               state_n = DONE;
               q_out_n = q_step;
               r_out_n = r_step;
               dz_n    = 1'b0;
            end
         end
         DONE: state_n = out_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         count  <= '0;
         q      <= '0;
         r      <= '0;
         d      <= '0;
         out_q  <= '0;
         out_r  <= '0;
         out_dz <= 1'b0;
      end else begin
         state  <= state_n;
         count  <= count_n;
         q      <= q_n;
         r      <= r_n;
         d      <= d_n;
         out_q  <= q_out_n;
         out_r  <= r_out_n;
         out_dz <= dz_n;
      end
   end
endmodule

// File: tb/tb_lab4_div5_ctrl.sv
// tb_lab4_div5_ctrl: directed and exhaustive checks of the 5-bit divider controller.
module tb_lab4_div5_ctrl;
   logic       clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [4:0] in_a = '0, in_b = '0;
   logic       in_ready, out_valid, out_dz;
   logic [4:0] out_q, out_r;
   int         n_tests = 0, n_fail = 0;

   lab4_div5_ctrl dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_q    (out_q),
      .out_r    (out_r),
      .out_dz   (out_dz)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // lat = clock edges after the accepting edge until out_valid is seen
   task automatic op(input logic [4:0] a, input logic [4:0] b, input int stall,
                     output logic [4:0] q, output logic [4:0] r, output logic dz, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      in_a      = a;
      in_b      = b;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      q = out_q;
      r = out_r;
      dz = out_dz;
      repeat (stall) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_tests++;
      if ({out_valid, out_q, out_r, out_dz} !== 12'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%0b q=%0d r=%0d dz=%0b want all 0", out_valid, out_q, out_r, out_dz);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %0b want 1", in_ready);
      end
   endtask

   task automatic test_basic();
      logic [4:0] q, r;
      logic       dz;
      int         lat;
      op(5'd23, 5'd5, 0, q, r, dz, lat);
      n_tests++;
      if (lat !== 5) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d want 5", lat);
      end
      n_tests++;
      if ({q, r, dz} !== {5'd4, 5'd3, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_23_5: got q=%0d r=%0d dz=%0b want q=4 r=3 dz=0", q, r, dz);
      end
   endtask

   task automatic test_patterns();
      logic [4:0] q, r;
      logic       dz;
      int         lat;
      logic [19:0] vec [3] = '{{5'd31, 5'd1, 5'd31, 5'd0},
                               {5'd31, 5'd31, 5'd1, 5'd0},
                               {5'd0, 5'd7, 5'd0, 5'd0}};
      for (int i = 0; i < 3; i++) begin
         op(vec[i][19:15], vec[i][14:10], 0, q, r, dz, lat);
         n_tests++;
         if ({q, r, dz} !== {vec[i][9:5], vec[i][4:0], 1'b0} || lat !== 5) begin
            n_fail++;
            $display("FAIL pattern_%0d: got q=%0d r=%0d dz=%0b lat=%0d want q=%0d r=%0d dz=0 lat=5",
                     i, q, r, dz, lat, vec[i][9:5], vec[i][4:0]);
         end
      end
   endtask

   task automatic test_div_zero();
      logic [4:0] q, r;
      logic       dz;
      int         lat;
      op(5'd9, 5'd0, 0, q, r, dz, lat);
      n_tests++;
      if (lat !== 0) begin
         n_fail++;
         $display("FAIL dz_latency: got %0d want 0", lat);
      end
      n_tests++;
      if ({q, r, dz} !== {5'd31, 5'd9, 1'b1}) begin
         n_fail++;
         $display("FAIL dz_9_0: got q=%0d r=%0d dz=%0b want q=31 r=9 dz=1", q, r, dz);
      end
   endtask

   task automatic test_stall();
      in_a     = 5'd30;
      in_b     = 5'd17;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if ({out_valid, in_ready, out_q, out_r, out_dz} !== {1'b1, 1'b0, 5'd1, 5'd13, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_hold_%0d: got v=%0b rdy=%0b q=%0d r=%0d dz=%0b want v=1 rdy=0 q=1 r=13 dz=0",
                     i, out_valid, in_ready, out_q, out_r, out_dz);
         end
         in_a     = 5'd2;
         in_b     = 5'd1;
         in_valid = 1'b1;
         @(posedge clk);
         #1 in_valid = 1'b0;
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_tests++;
      if ({out_valid, in_ready, out_q, out_r} !== {1'b0, 1'b1, 5'd1, 5'd13}) begin
         n_fail++;
         $display("FAIL stall_release: got v=%0b rdy=%0b q=%0d r=%0d want v=0 rdy=1 q=1 r=13",
                  out_valid, in_ready, out_q, out_r);
      end
   endtask

   task automatic test_reset_mid();
      logic [4:0] q, r;
      logic       dz;
      int         lat;
      in_a     = 5'd27;
      in_b     = 5'd4;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_tests++;
      if ({out_valid, out_q, out_r, out_dz} !== 12'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got v=%0b q=%0d r=%0d dz=%0b want all 0", out_valid, out_q, out_r, out_dz);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      op(5'd27, 5'd4, 0, q, r, dz, lat);
      n_tests++;
      if ({q, r, dz} !== {5'd6, 5'd3, 1'b0} || lat !== 5) begin
         n_fail++;
         $display("FAIL after_reset_27_4: got q=%0d r=%0d dz=%0b lat=%0d want q=6 r=3 dz=0 lat=5", q, r, dz, lat);
      end
   endtask

   task automatic test_sweep();
      logic [4:0] q, r, eq, er;
      logic       dz, edz;
      int         lat, elat;
      for (int a = 0; a < 32; a++) begin
         for (int b = 0; b < 32; b++) begin
            op(5'(a), 5'(b), int'($urandom_range(0, 2)), q, r, dz, lat);
            eq   = (b == 0) ? 5'd31 : 5'(a / b);
            er   = (b == 0) ? 5'(a) : 5'(a % b);
            edz  = (b == 0);
            elat = (b == 0) ? 0 : 5;
            n_tests++;
            if ({q, r, dz} !== {eq, er, edz} || lat !== elat) begin
               n_fail++;
               $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d dz=%0b lat=%0d want q=%0d r=%0d dz=%0b lat=%0d",
                        a, b, q, r, dz, lat, eq, er, edz, elat);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_patterns();
      test_div_zero();
      test_stall();
      test_reset_mid();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
